// File: rtl/tank_sprite_if.sv
// Pixel stream, tank state and rendered output for the tank sprite pipeline.
// The renderer takes the slave side; the video front end drives the master side.
interface tank_sprite_if #(parameter int NUM_TANKS = 2);
  logic                     i_valid;
  logic [5:0]               i_game_x, i_game_y;
  logic [3:0]               i_grid_x, i_grid_y;
  logic [23:0]              i_bg_rgb;
  logic                     i_frame_start;
  logic [6*NUM_TANKS-1:0]   i_tank_x, i_tank_y;
  logic [2*NUM_TANKS-1:0]   i_tank_dir;
  logic [NUM_TANKS-1:0]     i_tank_alive, i_tank_moving, i_tank_hit;
  logic                     o_valid;
  logic [23:0]              o_rgb;
  logic [NUM_TANKS-1:0]     o_tank_hit_px;

  modport master (
    output i_valid, i_game_x, i_game_y, i_grid_x, i_grid_y, i_bg_rgb, i_frame_start,
           i_tank_x, i_tank_y, i_tank_dir, i_tank_alive, i_tank_moving, i_tank_hit,
    input  o_valid, o_rgb, o_tank_hit_px
  );
  modport slave (
    input  i_valid, i_game_x, i_game_y, i_grid_x, i_grid_y, i_bg_rgb, i_frame_start,
           i_tank_x, i_tank_y, i_tank_dir, i_tank_alive, i_tank_moving, i_tank_hit,
    output o_valid, o_rgb, o_tank_hit_px
  );
endinterface

// File: rtl/tank_sprite_pipe.sv
// Pipelined multi-tank sprite renderer: window/rotate (S1), label ROM (S2), palette + priority (S3).
// Sprite ROM and palette contents are generated from the address so the block is self-contained.
module tank_sprite_lane #(
  parameter int CELL = 10, SPAN = 5, LABEL_W = 2,
  parameter int ANIM_FRAMES = 2, ANIM_PERIOD = 8, FLASH_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [5:0]         game_x, game_y,
  input  logic [3:0]         grid_x, grid_y,
  input  logic [5:0]         tank_x, tank_y,
  input  logic [1:0]         dir,
  input  logic               alive, moving, hit,
  output logic               win_s2,
  output logic [LABEL_W-1:0] label_s2,
  output logic               flash_s2
);
  localparam int S  = SPAN * CELL;
  localparam int H  = (SPAN - 1) / 2;
  localparam int LW = $clog2(S);
  localparam int AW = $clog2(ANIM_FRAMES * S * S);
  localparam int FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int PW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam int CW = $clog2(FLASH_FRAMES + 1);

  logic [PW-1:0] per_cnt;
  logic [FW-1:0] frame;
  logic [CW-1:0] flash_cnt;
  logic [7:0]    dx, dy;
  logic [LW-1:0] lx, ly, row, col;
  logic [AW-1:0] addr, addr_s1;
  logic          win_s1, flash_s1;

  function automatic logic [LABEL_W-1:0] rom_label(input logic [AW-1:0] a);
    logic [1:0] t;
    t = a[1:0] ^ a[3:2] ^ {1'b0, ^a[AW-1:4]} ^ 2'b01;
    return LABEL_W'(t);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt   <= '0;
      frame     <= '0;
      flash_cnt <= '0;
    end else begin
      if (frame_start && moving) begin
        if (per_cnt == PW'(ANIM_PERIOD - 1)) begin
          per_cnt <= '0;
          frame   <= (frame == FW'(ANIM_FRAMES - 1)) ? '0 : frame + FW'(1);
        end else begin
          per_cnt <= per_cnt + PW'(1);
        end
      end
      if (hit)                               flash_cnt <= CW'(FLASH_FRAMES);
      else if (frame_start && flash_cnt != 0) flash_cnt <= flash_cnt - CW'(1);
    end
  end

  // Unsigned 8-bit offsets: anything left/above the window wraps to >= 128 and fails the compare.
  assign dx = {2'b0, game_x} - {2'b0, tank_x} + 8'(H);
  assign dy = {2'b0, game_y} - {2'b0, tank_y} + 8'(H);
  assign lx = LW'(16'(dx) * 16'(CELL) + 16'(grid_x));
  assign ly = LW'(16'(dy) * 16'(CELL) + 16'(grid_y));

  always_comb begin
    row = ly;
    col = lx;
    case (dir)
      2'd1: begin row = LW'(S - 1) - ly; col = LW'(S - 1) - lx; end
      2'd2: begin row = lx;              col = LW'(S - 1) - ly; end
      2'd3: begin row = LW'(S - 1) - lx; col = ly;              end
      default: ;
    endcase
  end

  assign addr = AW'(frame) * AW'(S * S) + AW'(row) * AW'(S) + AW'(col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_s1   <= 1'b0;
      addr_s1  <= '0;
      flash_s1 <= 1'b0;
      win_s2   <= 1'b0;
      label_s2 <= '0;
      flash_s2 <= 1'b0;
    end else begin
      win_s1   <= alive && (dx < 8'(SPAN)) && (dy < 8'(SPAN));
      addr_s1  <= addr;
      flash_s1 <= (flash_cnt != 0) && flash_cnt[2];
      win_s2   <= win_s1;
      label_s2 <= rom_label(addr_s1);
      flash_s2 <= flash_s1;
    end
  end
endmodule

module tank_sprite_pipe #(
  parameter int NUM_TANKS = 2, CELL = 10, SPAN = 5, LABEL_W = 2,
  parameter int ANIM_FRAMES = 2, ANIM_PERIOD = 8, FLASH_FRAMES = 60
) (
  input  logic          i_clk,
  input  logic          i_rst,
  tank_sprite_if.slave  bus
);
  localparam int STAGES = 3;

  logic [STAGES:1]                      vld_pipe;
  logic [23:0]                          bg_s1, bg_s2, rgb, rgb_nxt;
  logic [NUM_TANKS-1:0]                 win_s2, flash_s2, own, own_nxt;
  logic [NUM_TANKS-1:0][LABEL_W-1:0]    label_s2;

  function automatic logic [23:0] pal_color(input int idx);
    return {8'(idx), ~8'(idx), 8'h5A};
  endfunction

  for (genvar k = 0; k < NUM_TANKS; k++) begin : g_lane
    tank_sprite_lane #(
      .CELL(CELL), .SPAN(SPAN), .LABEL_W(LABEL_W),
      .ANIM_FRAMES(ANIM_FRAMES), .ANIM_PERIOD(ANIM_PERIOD), .FLASH_FRAMES(FLASH_FRAMES)
    ) u_lane (
      .clk(i_clk), .rst(i_rst), .frame_start(bus.i_frame_start),
      .game_x(bus.i_game_x), .game_y(bus.i_game_y),
      .grid_x(bus.i_grid_x), .grid_y(bus.i_grid_y),
      .tank_x(bus.i_tank_x[6*k +: 6]), .tank_y(bus.i_tank_y[6*k +: 6]),
      .dir(bus.i_tank_dir[2*k +: 2]),
      .alive(bus.i_tank_alive[k]), .moving(bus.i_tank_moving[k]), .hit(bus.i_tank_hit[k]),
      .win_s2(win_s2[k]), .label_s2(label_s2[k]), .flash_s2(flash_s2[k])
    );
  end

  // Lowest-index opaque tank wins; flash recolours only the winner's pixel.
  always_comb begin
    logic found;
    found   = 1'b0;
    rgb_nxt = bg_s2;
    own_nxt = '0;
    for (int k = 0; k < NUM_TANKS; k++) begin
      if (!found && win_s2[k] && label_s2[k] != '0) begin
        found      = 1'b1;
        own_nxt[k] = 1'b1;
        rgb_nxt    = flash_s2[k] ? 24'hFFFFFF
                                 : pal_color(k * (1 << LABEL_W) + int'(label_s2[k]));
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe <= '0;
      bg_s1    <= '0;
      bg_s2    <= '0;
      rgb      <= '0;
      own      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.i_valid};
      bg_s1    <= bus.i_bg_rgb;
      bg_s2    <= bg_s1;
      rgb      <= rgb_nxt;
      own      <= own_nxt;
    end
  end

  assign bus.o_valid       = vld_pipe[STAGES];
  assign bus.o_rgb         = rgb;
  assign bus.o_tank_hit_px = own;
endmodule

// File: tb/tb_tank_sprite_pipe.sv
// Directed bench for tank_sprite_pipe: table of single-pixel vectors plus animation, flash and reset sequences.
module tb_tank_sprite_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tank_sprite_if #(.NUM_TANKS(2)) bus ();
  tank_sprite_pipe dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct {
    logic [5:0]  t0x, t0y; logic [1:0] t0d;
    logic [5:0]  t1x, t1y; logic [1:0] t1d;
    logic [1:0]  alive;
    logic [5:0]  gx, gy; logic [3:0] sx, sy;
    logic [23:0] bg, rgb;
    logic [1:0]  own;
  } vec_t;

  localparam logic [23:0] BG = 24'hABCDEF;
  localparam logic [23:0] C1 = 24'h01FE5A, C2 = 24'h02FD5A, C3 = 24'h03FC5A;
  localparam logic [23:0] C5 = 24'h05FA5A, WH = 24'hFFFFFF;

  vec_t vecs[15];
  int n_vec = 0, n_bad = 0;
  logic        got_v;
  logic [23:0] got_rgb;
  logic [1:0]  got_own;

  function automatic vec_t mk(input logic [5:0] t0x, t0y, input logic [1:0] t0d,
                              input logic [5:0] t1x, t1y, input logic [1:0] t1d,
                              input logic [1:0] alive, input logic [5:0] gx, gy,
                              input logic [3:0] sx, sy, input logic [23:0] rgb,
                              input logic [1:0] own);
    vec_t v;
    v = '{t0x, t0y, t0d, t1x, t1y, t1d, alive, gx, gy, sx, sy, BG, rgb, own};
    return v;
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_tanks(input vec_t v);
    bus.i_tank_x     = {v.t1x, v.t0x};
    bus.i_tank_y     = {v.t1y, v.t0y};
    bus.i_tank_dir   = {v.t1d, v.t0d};
    bus.i_tank_alive = v.alive;
  endtask

  // One pixel in, result sampled just after the third rising edge.
  task automatic run_px(input logic [5:0] gx, gy, input logic [3:0] sx, sy, input logic [23:0] bg);
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_game_x = gx; bus.i_game_y = gy;
    bus.i_grid_x = sx; bus.i_grid_y = sy; bus.i_bg_rgb = bg;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_bg_rgb = 24'h0;
    repeat (2) @(posedge clk);
    #1;
    got_v = bus.o_valid; got_rgb = bus.o_rgb; got_own = bus.o_tank_hit_px;
  endtask

  task automatic fs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus.i_frame_start = 1'b1;
      @(negedge clk); bus.i_frame_start = 1'b0;
    end
  endtask

  task automatic hit_pulse(input logic with_fs);
    @(negedge clk); bus.i_tank_hit = 2'b01; bus.i_frame_start = with_fs;
    @(negedge clk); bus.i_tank_hit = 2'b00; bus.i_frame_start = 1'b0;
  endtask

  // Tank 0 at (10,10) up, pixel at its top-left corner: frame 0 -> C1, frame 1 -> transparent.
  task automatic probe(input string name, input logic [23:0] exp_rgb, input logic [1:0] exp_own);
    run_px(6'd8, 6'd8, 4'd0, 4'd0, BG);
    check({name, " rgb"}, got_rgb, exp_rgb);
    check({name, " own"}, {22'd0, got_own}, {22'd0, exp_own});
  endtask

  initial begin
    bus.i_valid = 0; bus.i_game_x = 0; bus.i_game_y = 0; bus.i_grid_x = 0; bus.i_grid_y = 0;
    bus.i_bg_rgb = 0; bus.i_frame_start = 0; bus.i_tank_x = 0; bus.i_tank_y = 0;
    bus.i_tank_dir = 0; bus.i_tank_alive = 0; bus.i_tank_moving = 0; bus.i_tank_hit = 0;

    vecs[0]  = mk(10, 10, 0, 50, 50, 0, 3,  8,  8, 0, 0, C1, 2'b01); // corner, addr 0
    vecs[1]  = mk( 1,  5, 0, 50, 50, 0, 3, 63,  5, 0, 0, BG, 2'b00); // no 6-bit wrap
    vecs[2]  = mk( 1,  5, 0, 50, 50, 0, 3,  0,  5, 0, 0, C3, 2'b01); // lx=10 ly=20
    vecs[3]  = mk(20, 20, 0, 20, 20, 0, 3, 18, 18, 0, 0, C1, 2'b01); // tank 0 priority
    vecs[4]  = mk(20, 20, 2, 20, 20, 0, 3, 18, 18, 0, 0, C5, 2'b10); // tank 0 transparent
    vecs[5]  = mk(10, 10, 3, 50, 50, 0, 3,  8,  8, 0, 0, C3, 2'b01); // right -> addr 2450
    vecs[6]  = mk(10, 10, 2, 50, 50, 0, 3,  8,  8, 0, 0, BG, 2'b00); // left -> addr 49
    vecs[7]  = mk(10, 10, 1, 50, 50, 0, 3,  8,  8, 0, 0, C2, 2'b01); // down -> addr 2499
    vecs[8]  = mk(10, 10, 0, 50, 50, 0, 2,  8,  8, 0, 0, BG, 2'b00); // tank 0 dead
    vecs[9]  = mk(10, 10, 0, 50, 50, 0, 3, 13, 10, 0, 0, BG, 2'b00); // dx = SPAN
    vecs[10] = mk(10, 10, 0, 50, 50, 0, 3, 12, 12, 9, 9, C2, 2'b01); // lx=ly=49
    vecs[11] = mk(10, 10, 0, 50, 50, 0, 3, 10, 10, 3, 7, C3, 2'b01); // addr 1373
    vecs[12] = mk(50, 50, 0, 10, 10, 0, 3,  8,  8, 0, 0, C5, 2'b10); // tank 1 only
    vecs[13] = mk( 5,  0, 0, 50, 50, 0, 3,  5,  0, 0, 0, C2, 2'b01); // y clip, addr 1020
    vecs[14] = mk( 5,  0, 0, 50, 50, 0, 3,  5, 63, 0, 0, BG, 2'b00); // y wrap rejected

    repeat (3) @(posedge clk);
    #1;
    check("reset o_valid", {23'd0, bus.o_valid}, 24'd0);
    check("reset o_rgb", bus.o_rgb, 24'd0);
    check("reset own", {22'd0, bus.o_tank_hit_px}, 24'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      set_tanks(vecs[i]);
      run_px(vecs[i].gx, vecs[i].gy, vecs[i].sx, vecs[i].sy, vecs[i].bg);
      check($sformatf("vec%0d valid", i), {23'd0, got_v}, 24'd1);
      check($sformatf("vec%0d rgb", i), got_rgb, vecs[i].rgb);
      check($sformatf("vec%0d own", i), {22'd0, got_own}, {22'd0, vecs[i].own});
    end

    // Animation on tank 0
    set_tanks(vecs[0]);
    bus.i_tank_moving = 2'b01;
    fs_pulses(7);  probe("anim 7", C1, 2'b01);
    fs_pulses(1);  probe("anim 8", BG, 2'b00);
    bus.i_tank_moving = 2'b00;
    fs_pulses(8);  probe("anim hold f1", BG, 2'b00);
    bus.i_tank_moving = 2'b01; fs_pulses(4);
    bus.i_tank_moving = 2'b00; fs_pulses(4);
    bus.i_tank_moving = 2'b01; fs_pulses(3);
    probe("anim cnt held", BG, 2'b00);
    fs_pulses(1);  probe("anim wrap", C1, 2'b01);
    bus.i_tank_moving = 2'b00;

    // Hit flash on tank 0
    hit_pulse(1'b0); probe("flash 60", WH, 2'b01);
    fs_pulses(1);    probe("flash 59", C1, 2'b01);
    fs_pulses(4);    probe("flash 55", WH, 2'b01);
    set_tanks(vecs[6]);
    run_px(6'd8, 6'd8, 4'd0, 4'd0, BG);
    check("flash transparent", got_rgb, BG);
    set_tanks(vecs[0]);
    fs_pulses(4);    probe("flash 51", C1, 2'b01);
    fs_pulses(47);   probe("flash 4", WH, 2'b01);
    set_tanks(vecs[3]);
    run_px(6'd18, 6'd18, 4'd0, 4'd0, BG);
    check("flash prio own", {22'd0, got_own}, 24'd1);
    set_tanks(vecs[0]);
    fs_pulses(1);    probe("flash 3", C1, 2'b01);
    fs_pulses(4);    probe("flash 0", C1, 2'b01);
    hit_pulse(1'b1); probe("flash load wins", WH, 2'b01);
    fs_pulses(1);    probe("flash reload 59", C1, 2'b01);

    // Reset mid-stream: flush, then o_valid rises 3 cycles after first pixel
    @(negedge clk); bus.i_valid = 1'b1; bus.i_bg_rgb = BG;
    repeat (4) @(negedge clk);
    rst = 1'b1; #1;
    check("midreset o_valid", {23'd0, bus.o_valid}, 24'd0);
    check("midreset o_rgb", bus.o_rgb, 24'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("post reset 2cyc", {23'd0, bus.o_valid}, 24'd0);
    @(posedge clk); #1;
    check("post reset 3cyc", {23'd0, bus.o_valid}, 24'd1);
    check("post reset rgb", bus.o_rgb, C1);
    bus.i_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
